// File: rtl/pixel_compositor_pkg.sv
// Shared widths, pixel type and layer-slice helper for the pixel compositor.
package pixel_compositor_pkg;

    localparam int DEF_COLOR_W    = 4;
    localparam int DEF_NUM_LAYERS = 2;
    localparam int DEF_COL_W      = 12;
    localparam int DEF_ROW_W      = 11;
    localparam int DEF_SCROLL_W   = 12;
    localparam int DEF_BG_SHIFT   = 2;
    localparam int DEF_BG_COL_W   = 8;
    localparam int DEF_BG_ROW_W   = 8;
    localparam int DEF_MEM_LAT    = 1;
    localparam int RGB_W          = 3 * DEF_COLOR_W;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] b;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] r;
    } rgb_t;

    // Low bit of layer idx inside the flattened layer_rgb bus.
    function automatic int layer_lo(input int idx, input int pix_w);
        return idx * pix_w;
    endfunction

endpackage

// File: rtl/compositor_delay_line.sv
// Fixed-depth shift register used for every pipeline alignment delay.
module compositor_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Scrolling tiled background plus priority overlay layers, MEM_LAT+2 cycle pipeline.
// Define COMPOSITOR_COLORKEY_EN to make layers carrying KEY_RGB transparent.
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int COL_W      = DEF_COL_W,
    parameter int ROW_W      = DEF_ROW_W,
    parameter int SCROLL_W   = DEF_SCROLL_W,
    parameter int BG_SHIFT   = DEF_BG_SHIFT,
    parameter int BG_COL_W   = DEF_BG_COL_W,
    parameter int BG_ROW_W   = DEF_BG_ROW_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter logic [3*COLOR_W-1:0] KEY_RGB = {(3*COLOR_W){1'b1}}
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [COL_W-1:0]                 i_display_col,
    input  logic [ROW_W-1:0]                 i_display_row,
    input  logic                             i_visible,
    input  logic                             i_hsync_in,
    input  logic                             i_vsync_in,
    input  logic                             i_scroll_en,
    input  logic [SCROLL_W-1:0]              i_scroll_step,
    input  logic [NUM_LAYERS-1:0]            i_layer_valid,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0]  i_layer_rgb,
    output logic [BG_COL_W+BG_ROW_W-1:0]     o_bg_addr,
    input  logic [3*COLOR_W-1:0]             i_bg_q,
    output logic [COLOR_W-1:0]               o_vga_r,
    output logic [COLOR_W-1:0]               o_vga_g,
    output logic [COLOR_W-1:0]               o_vga_b,
    output logic                             o_hsync_out,
    output logic                             o_vsync_out
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int DW    = 3 + NUM_LAYERS + NUM_LAYERS * PIX_W;

    logic [SCROLL_W-1:0]            r_scroll;
    logic [BG_COL_W+BG_ROW_W-1:0]   r_bg_addr;
    logic [COLOR_W-1:0]             r_vga_r, r_vga_g, r_vga_b;
    logic                           r_hsync, r_vsync;

    logic                           w_frame_start;
    logic [COL_W-1:0]               w_bg_col;
    logic [DW-1:0]                  w_d_in, w_d_out;
    logic                           w_d_visible, w_d_hsync, w_d_vsync;
    logic [NUM_LAYERS-1:0]          w_d_valid, w_eff_valid;
    logic [NUM_LAYERS*PIX_W-1:0]    w_d_rgb;
    logic [PIX_W-1:0]               w_pix;
    logic                           w_unused;

    assign w_frame_start = (i_display_col == {COL_W{1'b0}}) && (i_display_row == {ROW_W{1'b0}});
    // Pixel in the frame-start cycle still uses the pre-advance offset.
    assign w_bg_col = i_display_col + COL_W'(r_scroll);
    assign w_unused = ^{w_bg_col};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scroll <= '0;
        end else if (w_frame_start && i_scroll_en) begin
            r_scroll <= r_scroll + i_scroll_step;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bg_addr <= '0;
        end else begin
            r_bg_addr <= {w_bg_col[BG_SHIFT+BG_COL_W-1:BG_SHIFT],
                          i_display_row[BG_SHIFT+BG_ROW_W-1:BG_SHIFT]};
        end
    end

    assign w_d_in = {i_visible, i_hsync_in, i_vsync_in, i_layer_valid, i_layer_rgb};

    compositor_delay_line #(
        .WIDTH (DW),
        .DEPTH (MEM_LAT + 1)
    ) u_align (
        .clock  (clock),
        .reset  (reset),
        .i_data (w_d_in),
        .o_data (w_d_out)
    );

    assign {w_d_visible, w_d_hsync, w_d_vsync, w_d_valid, w_d_rgb} = w_d_out;

    always_comb begin
        w_eff_valid = w_d_valid;
`ifdef COMPOSITOR_COLORKEY_EN
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_eff_valid[i] = w_d_valid[i] &&
                             (w_d_rgb[layer_lo(i, PIX_W) +: PIX_W] != KEY_RGB);
        end
`else
        w_eff_valid = w_d_valid;
`endif
    end

    // Walk from highest index down so the lowest-index valid layer wins last.
    always_comb begin
        w_pix = i_bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            w_pix = w_eff_valid[i] ? w_d_rgb[layer_lo(i, PIX_W) +: PIX_W] : w_pix;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= '0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_vga_r <= w_d_visible ? w_pix[COLOR_W-1:0]           : {COLOR_W{1'b0}};
            r_vga_g <= w_d_visible ? w_pix[2*COLOR_W-1:COLOR_W]   : {COLOR_W{1'b0}};
            r_vga_b <= w_d_visible ? w_pix[3*COLOR_W-1:2*COLOR_W] : {COLOR_W{1'b0}};
            r_hsync <= w_d_hsync;
            r_vsync <= w_d_vsync;
        end
    end

    assign o_bg_addr   = r_bg_addr;
    assign o_vga_r     = r_vga_r;
    assign o_vga_g     = r_vga_g;
    assign o_vga_b     = r_vga_b;
    assign o_hsync_out = r_hsync;
    assign o_vsync_out = r_vsync;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor at default parameters (latency 3).
module tb_pixel_compositor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] display_col;
    logic [10:0] display_row;
    logic        visible, hsync_in, vsync_in, scroll_en;
    logic [11:0] scroll_step;
    logic [1:0]  layer_valid;
    logic [23:0] layer_rgb;
    logic [15:0] bg_addr;
    logic [11:0] bg_q;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pixel_compositor dut (
        .clock         (clock),
        .reset         (reset),
        .i_display_col (display_col),
        .i_display_row (display_row),
        .i_visible     (visible),
        .i_hsync_in    (hsync_in),
        .i_vsync_in    (vsync_in),
        .i_scroll_en   (scroll_en),
        .i_scroll_step (scroll_step),
        .i_layer_valid (layer_valid),
        .i_layer_rgb   (layer_rgb),
        .o_bg_addr     (bg_addr),
        .i_bg_q        (bg_q),
        .o_vga_r       (vga_r),
        .o_vga_g       (vga_g),
        .o_vga_b       (vga_b),
        .o_hsync_out   (hsync_out),
        .o_vsync_out   (vsync_out)
    );

    wire [11:0] vga = {vga_b, vga_g, vga_r};

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic frame_start();
        display_col = 12'd0; display_row = 11'd0;
        tick(1);
        display_col = 12'd5; display_row = 11'd5;
        tick(1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        display_col = 12'd5; display_row = 11'd5;
        visible = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        scroll_en = 1'b0; scroll_step = 12'd0;
        layer_valid = 2'b00; layer_rgb = 24'h0; bg_q = 12'h0;
        tick(2);
        checks++; if (vga !== 12'h000) begin errors++; $display("FAIL reset_vga got=%h exp=000", vga); end
        checks++; if (bg_addr !== 16'h0000) begin errors++; $display("FAIL reset_bg_addr got=%h exp=0000", bg_addr); end
        checks++; if ({hsync_out, vsync_out} !== 2'b00) begin errors++; $display("FAIL reset_syncs got=%b exp=00", {hsync_out, vsync_out}); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single_layer();
        visible = 1'b1; bg_q = 12'h123;
        layer_valid = 2'b01; layer_rgb = {12'h000, 12'h0F0};
        tick(2);
        checks++; if (vga !== 12'h000) begin errors++; $display("FAIL single_early got=%h exp=000", vga); end
        tick(1);
        checks++; if (vga !== 12'h0F0) begin errors++; $display("FAIL single_layer got=%h exp=0F0", vga); end
        layer_valid = 2'b00;
        tick(3);
        checks++; if (vga !== 12'h123) begin errors++; $display("FAIL background got=%h exp=123", vga); end
    endtask

    task automatic test_priority();
        layer_valid = 2'b11; layer_rgb = {12'h00B, 12'hA00};
        tick(3);
        checks++; if (vga !== 12'hA00) begin errors++; $display("FAIL priority_both got=%h exp=A00", vga); end
        layer_valid = 2'b10;
        tick(3);
        checks++; if (vga !== 12'h00B) begin errors++; $display("FAIL priority_l1 got=%h exp=00B", vga); end
    endtask

    task automatic test_visible_sync();
        visible = 1'b0; layer_valid = 2'b11;
        tick(3);
        checks++; if (vga !== 12'h000) begin errors++; $display("FAIL blanked got=%h exp=000", vga); end
        hsync_in = 1'b1;
        tick(1);
        hsync_in = 1'b0;
        tick(1);
        checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL hsync_early got=%b exp=0", hsync_out); end
        tick(1);
        checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL hsync_pulse got=%b exp=1", hsync_out); end
        tick(1);
        checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL hsync_end got=%b exp=0", hsync_out); end
    endtask

    task automatic test_scroll();
        pulse_reset();
        scroll_en = 1'b1; scroll_step = 12'd4;
        frame_start(); frame_start(); frame_start();
        display_col = 12'd0; display_row = 11'd8;
        tick(1);
        checks++; if (bg_addr !== 16'h0302) begin errors++; $display("FAIL scroll_addr got=%h exp=0302", bg_addr); end
        display_col = 12'h400; display_row = 11'd0;
        tick(1);
        checks++; if (bg_addr !== 16'h0300) begin errors++; $display("FAIL col_wrap got=%h exp=0300", bg_addr); end
    endtask

    task automatic test_wrap();
        pulse_reset();
        scroll_en = 1'b1; scroll_step = 12'hFFC;
        frame_start();
        display_col = 12'd0; display_row = 11'd4;
        tick(1);
        checks++; if (bg_addr !== 16'hFF01) begin errors++; $display("FAIL offset_ffc got=%h exp=FF01", bg_addr); end
        scroll_step = 12'd8;
        frame_start();
        display_col = 12'd0; display_row = 11'd4;
        tick(1);
        checks++; if (bg_addr !== 16'h0101) begin errors++; $display("FAIL offset_wrap got=%h exp=0101", bg_addr); end
        scroll_en = 1'b0;
        frame_start(); frame_start();
        display_col = 12'd0; display_row = 11'd4;
        tick(1);
        checks++; if (bg_addr !== 16'h0101) begin errors++; $display("FAIL offset_hold got=%h exp=0101", bg_addr); end
        display_col = 12'd5; display_row = 11'd5;
    endtask

    task automatic test_colorkey();
        logic [11:0] exp_pix;
`ifdef COMPOSITOR_COLORKEY_EN
        exp_pix = 12'h456;
`else
        exp_pix = 12'hFFF;
`endif
        visible = 1'b1; bg_q = 12'h123;
        layer_valid = 2'b11; layer_rgb = {12'h456, 12'hFFF};
        tick(3);
        checks++; if (vga !== exp_pix) begin errors++; $display("FAIL colorkey got=%h exp=%h", vga, exp_pix); end
    endtask

    task automatic test_reset_midline();
        layer_valid = 2'b01; layer_rgb = {12'h000, 12'h789};
        hsync_in = 1'b1; display_col = 12'd40; display_row = 11'd40;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (vga !== 12'h000) begin errors++; $display("FAIL midreset_vga got=%h exp=000", vga); end
        checks++; if (bg_addr !== 16'h0000) begin errors++; $display("FAIL midreset_addr got=%h exp=0000", bg_addr); end
        checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL midreset_hsync got=%b exp=0", hsync_out); end
        reset = 1'b0;
        tick(1);
        checks++; if (vga !== 12'h000) begin errors++; $display("FAIL refill_1 got=%h exp=000", vga); end
        tick(1);
        checks++; if (vga !== 12'h000) begin errors++; $display("FAIL refill_2 got=%h exp=000", vga); end
        tick(1);
        checks++; if (vga !== 12'h789) begin errors++; $display("FAIL refill_3 got=%h exp=789", vga); end
        hsync_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_priority();
        test_visible_sync();
        test_scroll();
        test_wrap();
        test_colorkey();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
